// File: rtl/clock_ratio_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_ratio_detector_pkg
// Description : Shared definitions for the clock ratio detector: FSM state
//               encoding, the ratio width shared with the clock divider, and
//               a helper that sizes the stability match counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package clock_ratio_detector_pkg;

  // Ratio encoding width used by both the divider and this detector.
  localparam int RATIO_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } crd_state_t;

  // The match counter can momentarily hold STABLE_COUNT+1 (STABLE_COUNT=1
  // after a re-entry into MEASURE), so size it for that value.
  function automatic int match_width(input int stable_count);
    return $clog2(stable_count + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_ratio_detector_clk_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : clk_edge_sync
// Description : Brings the asynchronous measured clock into the reference
//               domain and derives single-cycle rise/fall strobes.
// Ports       : i_ref_clk  - reference clock
//               i_rst      - asynchronous active-low reset
//               i_meas_clk - asynchronous clock under measurement
//               o_sync     - synchronized level of i_meas_clk
//               o_rise     - one-cycle strobe on a synchronized rising edge
//               o_fall     - one-cycle strobe on a synchronized falling edge
// Revision    : 1.0 - initial release
// ============================================================================
module clk_edge_sync
  import clock_ratio_detector_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_ref_clk,
  input  logic i_rst,
  input  logic i_meas_clk,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync_chain;
  logic                   r_prev;

  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync_chain <= '0;
      r_prev       <= 1'b0;
    end else begin
      r_sync_chain <= {r_sync_chain[SYNC_STAGES-2:0], i_meas_clk};
      r_prev       <= r_sync_chain[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync_chain[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/clock_ratio_detector.sv
`default_nettype none
// ============================================================================
// Module      : clock_ratio_detector
// Description : Measures the period of a slow free-running clock in
//               reference-clock cycles, locks once the period is stable, and
//               reports the period, its high-phase length and a timeout flag.
// Ports       : i_ref_clk  - reference clock (all logic on rising edge)
//               i_rst      - asynchronous active-low reset
//               i_en       - measurement enable; low clears everything
//               i_meas_clk - asynchronous clock under measurement
//               o_ratio    - locked period in reference cycles
//               o_high     - most recent measured high-phase length
//               o_valid    - o_ratio/o_high valid (LOCKED)
//               o_update   - one-cycle pulse when o_ratio is loaded
//               o_timeout  - no rising edge within 2^RATIO_WIDTH cycles
// Revision    : 1.0 - initial release
// ============================================================================
module clock_ratio_detector
  import clock_ratio_detector_pkg::*;
#(
  parameter int RATIO_WIDTH  = RATIO_WIDTH_DEFAULT,
  parameter int STABLE_COUNT = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_meas_clk,
  output logic [RATIO_WIDTH-1:0] o_ratio,
  output logic [RATIO_WIDTH-1:0] o_high,
  output logic                   o_valid,
  output logic                   o_update,
  output logic                   o_timeout
);

  localparam int c_CW = RATIO_WIDTH + 1;
  localparam int c_MW = match_width(STABLE_COUNT);
  localparam logic [c_CW-1:0] c_CNT_SAT    = {1'b1, {RATIO_WIDTH{1'b0}}};
  localparam logic [c_CW-1:0] c_HCNT_SAT   = {c_CW{1'b1}};
  localparam logic [c_MW-1:0] c_MATCH_LOCK = c_MW'(STABLE_COUNT);

  logic w_sync, w_rise, w_fall;

  clk_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .i_ref_clk  (i_ref_clk),
    .i_rst      (i_rst),
    .i_meas_clk (i_meas_clk),
    .o_sync     (w_sync),
    .o_rise     (w_rise),
    .o_fall     (w_fall)
  );

  crd_state_t             r_state, w_state_nxt;
  logic [c_CW-1:0]        r_cnt, w_cnt_nxt;
  logic [c_CW-1:0]        r_hcnt, w_hcnt_nxt;
  logic [RATIO_WIDTH-1:0] r_hi_cap, w_hi_cap_nxt;
  logic [c_CW-1:0]        r_last_p, w_last_p_nxt;
  logic [c_MW-1:0]        r_match, w_match_nxt, w_match_sum;
  logic [RATIO_WIDTH-1:0] r_ratio, w_ratio_nxt;
  logic [RATIO_WIDTH-1:0] r_high, w_high_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   r_update, w_update_nxt;
  logic                   r_timeout, w_timeout_nxt;
  logic                   w_timeout_evt;

  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_hi_cap  <= '0;
      r_last_p  <= '0;
      r_match   <= '0;
      r_ratio   <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_update  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_hi_cap  <= w_hi_cap_nxt;
      r_last_p  <= w_last_p_nxt;
      r_match   <= w_match_nxt;
      r_ratio   <= w_ratio_nxt;
      r_high    <= w_high_nxt;
      r_valid   <= w_valid_nxt;
      r_update  <= w_update_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hcnt_nxt    = r_hcnt;
    w_hi_cap_nxt  = r_hi_cap;
    w_last_p_nxt  = r_last_p;
    w_match_nxt   = r_match;
    w_match_sum   = r_match;
    w_ratio_nxt   = r_ratio;
    w_high_nxt    = r_high;
    w_valid_nxt   = r_valid;
    w_update_nxt  = 1'b0;
    w_timeout_nxt = r_timeout;
    w_timeout_evt = (r_cnt == c_CNT_SAT);

    if (!i_en || (r_state == ST_IDLE)) begin
      w_state_nxt   = i_en ? ST_ACQUIRE : ST_IDLE;
      w_cnt_nxt     = '0;
      w_hcnt_nxt    = '0;
      w_hi_cap_nxt  = '0;
      w_last_p_nxt  = '0;
      w_match_nxt   = '0;
      w_ratio_nxt   = '0;
      w_high_nxt    = '0;
      w_valid_nxt   = 1'b0;
      w_timeout_nxt = 1'b0;
    end else begin
      // Period counter: restart on every rise; after a timeout it restarts
      // from zero so a later rise can clear the sticky flag.
      if (w_rise) begin
        w_cnt_nxt = c_CW'(1);
      end else if (w_timeout_evt) begin
        w_cnt_nxt = '0;
      end else if (r_cnt != c_CNT_SAT) begin
        w_cnt_nxt = r_cnt + c_CW'(1);
      end

      if (w_rise) begin
        w_hcnt_nxt = c_CW'(1);
      end else if (w_sync && (r_hcnt != c_HCNT_SAT)) begin
        w_hcnt_nxt = r_hcnt + c_CW'(1);
      end

      // High phases that overflow the output width report as all-ones.
      if (w_fall) begin
        w_hi_cap_nxt = r_hcnt[RATIO_WIDTH] ? {RATIO_WIDTH{1'b1}}
                                           : r_hcnt[RATIO_WIDTH-1:0];
      end

      if (w_timeout_evt) begin
        w_state_nxt   = ST_ACQUIRE;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b1;
        w_match_nxt   = '0;
      end else if (w_rise) begin
        w_timeout_nxt = 1'b0;
        case (r_state)
          ST_ACQUIRE: begin
            w_state_nxt = ST_MEASURE;
            w_match_nxt = '0;
          end
          ST_MEASURE: begin
            if (r_cnt == r_last_p) begin
              w_match_sum = r_match + c_MW'(1);
            end else begin
              w_last_p_nxt = r_cnt;
              w_match_sum  = c_MW'(1);
            end
            w_match_nxt = w_match_sum;
            if (w_match_sum >= c_MATCH_LOCK) begin
              w_state_nxt  = ST_LOCKED;
              w_ratio_nxt  = r_cnt[RATIO_WIDTH-1:0];
              w_high_nxt   = r_hi_cap;
              w_valid_nxt  = 1'b1;
              w_update_nxt = 1'b1;
            end
          end
          ST_LOCKED: begin
            if (r_cnt == {1'b0, r_ratio}) begin
              w_high_nxt = r_hi_cap;
            end else begin
              w_state_nxt  = ST_MEASURE;
              w_valid_nxt  = 1'b0;
              w_last_p_nxt = r_cnt;
              w_match_nxt  = c_MW'(1);
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  assign o_ratio   = r_ratio;
  assign o_high    = r_high;
  assign o_valid   = r_valid;
  assign o_update  = r_update;
  assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_clock_ratio_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_ratio_detector
// Description : Self-checking bench for clock_ratio_detector. An event-level
//               model (edge timestamps, list of measured periods) predicts
//               every output each cycle; directed scenarios add literal
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clock_ratio_detector;

  localparam int RW       = 4;
  localparam int SC       = 2;
  localparam int SS       = 2;
  localparam int TO_LIMIT = 1 << RW;
  localparam int HI_MAX   = (1 << RW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_MEAS = 2;
  localparam int M_LOCK = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          meas  = 1'b0;
  logic [RW-1:0] ratio, high;
  logic          valid, update, timeout;

  clock_ratio_detector #(
    .RATIO_WIDTH  (RW),
    .STABLE_COUNT (SC),
    .SYNC_STAGES  (SS)
  ) dut (
    .i_ref_clk  (clk),
    .i_rst      (rst_n),
    .i_en       (en),
    .i_meas_clk (meas),
    .o_ratio    (ratio),
    .o_high     (high),
    .o_valid    (valid),
    .o_update   (update),
    .o_timeout  (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int updates = 0;
  int drops = 0;
  int valid_hi_cycles = 0;
  logic prev_valid = 1'b0;

  // ---------------- behavioural model ----------------
  int e = 0;
  int mode;
  int t_ref, h_ref, hi_cap;
  int hist[SS+1];
  int periods[$];
  int m_ratio, m_high;
  bit m_valid, m_update, m_timeout;

  task automatic model_clear_outputs();
    m_ratio = 0; m_high = 0; m_valid = 0; m_update = 0; m_timeout = 0;
    hi_cap = 0;
    periods.delete();
  endtask

  task automatic model_reset();
    mode = M_IDLE;
    t_ref = 0; h_ref = 0;
    for (int i = 0; i <= SS; i++) hist[i] = 0;
    model_clear_outputs();
  endtask

  function automatic bit stable_run();
    int n;
    n = periods.size();
    if (n < SC) return 1'b0;
    for (int i = n - SC; i < n; i++)
      if (periods[i] != periods[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit s, pv, rise, fall, to;
    int p;
    if (!rst_n) begin
      model_reset();
    end else begin
      s    = (hist[SS-1] != 0);
      pv   = (hist[SS] != 0);
      rise = s && !pv;
      fall = !s && pv;
      if (!en) begin
        mode = M_IDLE;
        model_clear_outputs();
      end else if (mode == M_IDLE) begin
        mode  = M_ACQ;
        t_ref = e + 1;
        h_ref = e + 1;
      end else begin
        p = e - t_ref;
        if (p > TO_LIMIT) p = TO_LIMIT;
        to = (p >= TO_LIMIT);
        m_update = 0;
        if (to) begin
          mode = M_ACQ; m_valid = 0; m_timeout = 1;
          periods.delete();
        end else if (rise) begin
          m_timeout = 0;
          if (mode == M_ACQ) begin
            mode = M_MEAS;
            periods.delete();
          end else if (mode == M_MEAS) begin
            periods.push_back(p);
            if (stable_run()) begin
              mode = M_LOCK; m_ratio = p; m_high = hi_cap;
              m_valid = 1; m_update = 1;
            end
          end else begin
            if (p == m_ratio) m_high = hi_cap;
            else begin
              mode = M_MEAS; m_valid = 0;
              periods.delete();
              periods.push_back(p);
            end
          end
        end
        if (fall) hi_cap = (e - h_ref > HI_MAX) ? HI_MAX : (e - h_ref);
        if (rise) begin
          t_ref = e; h_ref = e;
        end else if (to) begin
          t_ref = e + 1;
        end
      end
      for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(meas);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      e++;
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (ratio !== RW'(m_ratio) || high !== RW'(m_high) || valid !== m_valid ||
          update !== m_update || timeout !== m_timeout) begin
        errors++;
        $display("FAIL model_cmp t=%0t ratio %0d exp %0d high %0d exp %0d valid %0b exp %0b update %0b exp %0b timeout %0b exp %0b",
                 $time, ratio, m_ratio, high, m_high, valid, m_valid,
                 update, m_update, timeout, m_timeout);
      end
      if (update === 1'b1) updates++;
      if (valid === 1'b1) valid_hi_cycles++;
      if (prev_valid === 1'b1 && valid === 1'b0) drops++;
      prev_valid = valid;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_clk(input int hi, input int lo, input int n);
    repeat (n) begin
      meas = 1'b1;
      repeat (hi) @(negedge clk);
      meas = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  int u0, d0, v0;

  initial begin
    cycles(3);
    lit("reset_ratio", int'(ratio), 0);
    lit("reset_high", int'(high), 0);
    lit("reset_valid", int'(valid), 0);
    lit("reset_update", int'(update), 0);
    lit("reset_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    cycles(2);

    // Ratio 4, 2 high / 2 low
    en = 1'b1;
    u0 = updates;
    run_clk(2, 2, 8);
    lit("r4_valid", int'(valid), 1);
    lit("r4_ratio", int'(ratio), 4);
    lit("r4_high", int'(high), 2);
    lit("r4_updates", updates - u0, 1);
    lit("model_ratio4", m_ratio, 4);

    // Ratio 5, then switch to ratio 7
    run_clk(2, 3, 8);
    lit("r5_ratio", int'(ratio), 5);
    lit("r5_high", int'(high), 2);
    u0 = updates; d0 = drops;
    run_clk(3, 4, 8);
    lit("r7_ratio", int'(ratio), 7);
    lit("r7_high", int'(high), 3);
    lit("r7_valid", int'(valid), 1);
    lit("r7_updates", updates - u0, 1);
    lit("r7_dropped", (drops > d0) ? 1 : 0, 1);

    // Stop the measured clock while locked, then restart at ratio 6
    meas = 1'b0;
    cycles(24);
    lit("stop_timeout", int'(timeout), 1);
    lit("stop_valid", int'(valid), 0);
    run_clk(3, 3, 8);
    lit("r6_timeout", int'(timeout), 0);
    lit("r6_ratio", int'(ratio), 6);
    lit("r6_high", int'(high), 3);
    lit("model_ratio6", m_ratio, 6);

    // Period 16 is out of range: never locks, timeout keeps firing
    u0 = updates;
    run_clk(8, 8, 6);
    lit("p16_valid", int'(valid), 0);
    lit("p16_timeout", int'(timeout), 1);
    lit("p16_updates", updates - u0, 0);

    // Enable drop while locked
    run_clk(2, 2, 6);
    lit("en_pre_valid", int'(valid), 1);
    en = 1'b0;
    cycles(1);
    lit("en_off_ratio", int'(ratio), 0);
    lit("en_off_high", int'(high), 0);
    lit("en_off_valid", int'(valid), 0);
    lit("en_off_timeout", int'(timeout), 0);
    en = 1'b1;
    u0 = updates;
    run_clk(2, 2, 6);
    lit("reen_ratio", int'(ratio), 4);
    lit("reen_updates", updates - u0, 1);

    // Asynchronous reset in MEASURE after a mismatching period
    run_clk(2, 3, 2);
    lit("mid_meas_valid", int'(valid), 0);
    lit("mid_meas_ratio_held", int'(ratio), 4);
    #2 rst_n = 1'b0;
    #1;
    lit("arst_ratio", int'(ratio), 0);
    lit("arst_high", int'(high), 0);
    lit("arst_valid", int'(valid), 0);
    cycles(2);
    rst_n = 1'b1;
    run_clk(2, 2, 6);
    lit("post_rst_valid", int'(valid), 1);
    lit("post_rst_ratio", int'(ratio), 4);

    // Alternating 4/5 periods must never lock
    en = 1'b0;
    cycles(2);
    en = 1'b1;
    u0 = updates; v0 = valid_hi_cycles;
    repeat (6) begin
      run_clk(2, 2, 1);
      run_clk(2, 3, 1);
    end
    lit("alt_valid_cycles", valid_hi_cycles - v0, 0);
    lit("alt_updates", updates - u0, 0);

    cycles(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_ratio_detector.md
# clock_ratio_detector

Measures the frequency ratio of a slow, free-running clock (typically the output of the system clock divider) against the reference clock, and reports it as an integer divide ratio. It sits in the `i_ref_clk` domain as a self-check and receive-side companion to the divider. The same `RATIO_WIDTH` encoding is used on both sides, so firmware can compare the programmed ratio with the measured one. It also reports the high-phase length and flags a stopped or too-slow clock.

## Interface
- `RATIO_WIDTH`, 4: width of the ratio and high-count outputs. Measurable periods are 2 .. 2^RATIO_WIDTH−1.
- `STABLE_COUNT`, 2: number of consecutive identical period measurements required to lock (≥1).
- `SYNC_STAGES`, 2: synchronizer depth for `i_meas_clk` (≥2).
- `i_ref_clk`  in  1  reference clock. All logic runs on its rising edge.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_en`  in  1  measurement enable. Low forces IDLE and clears all outputs.
- `i_meas_clk`  in  1  clock under measurement. Asynchronous; treated as data.
- `o_ratio`  out  RATIO_WIDTH  locked period, in `i_ref_clk` cycles.
- `o_high`  out  RATIO_WIDTH  high-phase length, in `i_ref_clk` cycles, of the most recent measured high phase.
- `o_valid`  out  1  `o_ratio` and `o_high` are valid (state LOCKED).
- `o_update`  out  1  one-cycle pulse when `o_ratio` is loaded with a new value.
- `o_timeout`  out  1  no rising edge seen within 2^RATIO_WIDTH cycles. Sticky until the next rising edge.

## Operation
- **Front end:**
  - `i_meas_clk` passes through `SYNC_STAGES` flops, then one more flop (`prev`).
  - `rise` = `sync & ~prev`; `fall` = `~sync & prev`.
- **Period counter `cnt`:**
  - Width is RATIO_WIDTH+1.
  - On `rise`: capture `p = cnt`, then load `cnt <= 1`.
  - Otherwise: `cnt <= cnt + 1`, saturating at 2^RATIO_WIDTH.
- **High counter `hcnt`:**
  - Width is RATIO_WIDTH+1.
  - On `rise`: load 1. While `sync` is high: increment (saturating).
  - On `fall`: `hi_cap <= hcnt`.
- **FSM states:** IDLE, ACQUIRE, MEASURE, LOCKED.
  - **IDLE:** counters, `last_p`, `match` and all outputs are held at 0. `i_en=1` → ACQUIRE.
  - **ACQUIRE:** the first `rise` only arms the counter, with no measurement. → MEASURE with `match=0`.
  - **MEASURE:** on `rise`:
    - If `p == last_p`, then `match++`. Otherwise `last_p <= p` and `match <= 1`.
    - When `match` reaches `STABLE_COUNT`: → LOCKED; `o_ratio <= p`; `o_high <= hi_cap`; `o_valid <= 1`; pulse `o_update`.
  - **LOCKED:**
    - `rise` with `p == o_ratio`: stay; `o_high <= hi_cap`.
    - `rise` with `p != o_ratio`: → MEASURE; `o_valid <= 0`; `last_p <= p`; `match <= 1`.
- **Timeout (ACQUIRE/MEASURE/LOCKED):**
  - Trigger: `cnt == 2^RATIO_WIDTH`, checked every cycle, including a coincident `rise`.
  - Result: → ACQUIRE; `o_valid <= 0`; `o_timeout <= 1`; `match <= 0`.
  - `o_timeout` clears on the next `rise`.
- **Enable:** `i_en` low in any state → IDLE on the next edge. `o_valid`, `o_update` and `o_timeout` go to 0.
- **Simultaneous events:**
  - Timeout has priority over a measurement.
  - `i_en=0` has priority over everything else.
- **Unsupported input:** ratio 1, or a high/low phase shorter than one ref cycle, is not supported. The outputs are then undefined, but the FSM must never hang: timeout and `i_en` still work.

## Timing
- **Reset values:** `o_ratio=0`, `o_high=0`, `o_valid=0`, `o_update=0`, `o_timeout=0`; state IDLE.
- **Edge latency:** `i_meas_clk` edge to `rise`/`fall` takes `SYNC_STAGES+1` ref edges, with ±1 cycle of synchronizer uncertainty.
- **Lock time:** `o_valid` rises on the cycle after the (STABLE_COUNT+1)-th synchronized rise following enable.
- **`o_update`:** exactly one cycle wide, coincident with the first `o_valid=1` cycle of each lock.
- **Loss of lock:** `o_valid` drops one cycle after a mismatching `rise` or after the timeout condition.

## Structure
- **Shared header/package:** FSM state encoding (IDLE=0, ACQUIRE=1, MEASURE=2, LOCKED=3). The `RATIO_WIDTH` default is shared with the clock divider.
- **Sub-module `clk_edge_sync`:** the `SYNC_STAGES` synchronizer, the `prev` flop, and the `rise`/`fall` outputs. Reset and clock are the same as the top level.
- **Top level:** counters, `match`, FSM and output registers.

## Test plan
- Enable, then drive a ratio-4 clock (2 high / 2 low) → `o_valid=1` after the 3rd synchronized rise; `o_ratio=4`; `o_high=2`; one `o_update` pulse.
- Drive a ratio-5 clock (2 high / 3 low), then switch to a ratio-7 clock (3 high / 4 low) mid-run:
  - Before the switch: `o_ratio=5`, `o_high=2`.
  - On the first 7-cycle period: `o_valid` drops, then relocks with `o_ratio=7`, `o_high=3` and a new `o_update`.
- Stop `i_meas_clk` while LOCKED:
  - 16 cycles after the last rise: `o_timeout=1`, `o_valid=0`.
  - Restart at ratio 6: `o_timeout` clears on the first rise; relock gives `o_ratio=6`.
- Drive a period of 16 with RATIO_WIDTH=4 → never locks; `o_timeout` asserts every period.
- Deassert `i_en` while LOCKED, or assert `i_rst` mid-MEASURE → all outputs 0 on the next edge (async for `i_rst`). Re-enable → fresh lock after STABLE_COUNT+1 rises.
- Alternate periods of 4 and 5 with STABLE_COUNT=2 → `o_valid` stays 0 and `o_update` never pulses.
